// File: rtl/lipsi_pkg.sv
// lipsi_pkg: shared types and default sizing for the Lipsi trace logic.
//   lipsi_trace_state_e : tracer FSM states (IDLE, ARM, RUN)
//   LIPSI_DATA_W / LIPSI_DEPTH / LIPSI_TS_W : default tracer parameters
package lipsi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } lipsi_trace_state_e;

    localparam int unsigned LIPSI_DATA_W = 8;
    localparam int unsigned LIPSI_DEPTH  = 16;
    localparam int unsigned LIPSI_TS_W   = 16;

endpackage

// File: rtl/lipsi_trace_fifo.sv
// lipsi_trace_fifo: circular first-word-fall-through FIFO for trace entries.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous flush (wins over push/pop)
//   push, din    : write request and data; accepted when not full or popping
//   pop          : consume head entry (ignored when empty)
//   dout         : head entry (valid when !empty)
//   full, empty  : occupancy flags
//   level        : number of stored entries, 0..DEPTH
module lipsi_trace_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         wr_en;
    logic         rd_en;

    // Extra pointer bit distinguishes full from empty when addresses match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    // A pop frees the head slot this cycle, so a push into a full FIFO is
    // still accepted; when full the write lands on the slot being read.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign dout = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/lipsi_acc_tracer.sv
// lipsi_acc_tracer: records every change of the Lipsi accumulator into a
// circular trace buffer drained through a valid/ready port.
//   clk, reset_n   : clock, asynchronous active-low reset
//   en             : capture enable
//   clear          : synchronous flush of buffer, overflow flag and timestamp
//   acc_in         : processor accumulator
//   out_valid/out_ready/out_data/out_ts : FWFT drain port (zero when empty)
//   overflow       : sticky, at least one change was dropped
//   level          : current entry count
// Build option LIPSI_TRACE_TS_EN: adds the cycle timestamp counter and stores
// it with each entry; without it out_ts is tied to zero.
module lipsi_acc_tracer
    import lipsi_pkg::*;
#(
    parameter int unsigned DATA_W = LIPSI_DATA_W,
    parameter int unsigned DEPTH  = LIPSI_DEPTH,
    parameter int unsigned TS_W   = LIPSI_TS_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     clear,
    input  logic [DATA_W-1:0]        acc_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [TS_W-1:0]          out_ts,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

`ifdef LIPSI_TRACE_TS_EN
    localparam int unsigned ENTRY_W = DATA_W + TS_W;
`else
    localparam int unsigned ENTRY_W = DATA_W;
`endif

    lipsi_trace_state_e state;
    lipsi_trace_state_e next_state;
    lipsi_trace_state_e mode;

    logic [DATA_W-1:0]  prev_acc;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] din;
    logic [ENTRY_W-1:0] dout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // 'mode' is the state in effect this cycle: the first enabled cycle is
    // ARM straight away, so the ARM sample carries the counter value at the
    // first enabled edge. The register therefore only ever holds IDLE or RUN.
    always_comb begin
        mode       = IDLE;
        next_state = IDLE;
        push       = 1'b0;
        if (en) begin
            mode = (state == RUN) ? RUN : ARM;
        end
        unique case (mode)
            ARM:     begin push = 1'b1;                  next_state = RUN;  end
            RUN:     begin push = (acc_in != prev_acc);  next_state = RUN;  end
            default: begin push = 1'b0;                  next_state = IDLE; end
        endcase
        if (clear) begin
            push       = 1'b0;
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     prev_acc <= '0;
        else if (en)      prev_acc <= acc_in;
    end

    assign out_valid = !empty;
    assign pop       = !empty && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                     overflow <= 1'b0;
        else if (clear)                   overflow <= 1'b0;
        else if (push && full && !pop)    overflow <= 1'b1;
    end

`ifdef LIPSI_TRACE_TS_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   ts_cnt <= '0;
        else if (clear) ts_cnt <= '0;
        else if (en)    ts_cnt <= ts_cnt + 1'b1;
    end

    assign din      = {ts_cnt, acc_in};
    assign out_data = empty ? '0 : dout[DATA_W-1:0];
    assign out_ts   = empty ? '0 : dout[ENTRY_W-1:DATA_W];
`else
    assign din      = acc_in;
    assign out_data = empty ? '0 : dout;
    assign out_ts   = '0;
`endif

    lipsi_trace_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .push    (push),
        .pop     (pop),
        .din     (din),
        .dout    (dout),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

endmodule

// File: tb/tb_lipsi_acc_tracer.sv
// tb_lipsi_acc_tracer: directed self-checking bench for lipsi_acc_tracer.
// Timestamp expectations collapse to zero unless LIPSI_TRACE_TS_EN is defined.
module tb_lipsi_acc_tracer;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned TS_W   = 16;
    localparam int unsigned LW     = $clog2(DEPTH) + 1;

`ifdef LIPSI_TRACE_TS_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              en;
    logic              clear;
    logic [DATA_W-1:0] acc_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TS_W-1:0]   out_ts;
    logic              overflow;
    logic [LW-1:0]     level;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    lipsi_acc_tracer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TS_W   (TS_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .clear     (clear),
        .acc_in    (acc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ts    (out_ts),
        .overflow  (overflow),
        .level     (level)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ets(input int unsigned t);
        return TS_ON ? 32'(t) : 32'd0;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string tag, input logic v, input logic [31:0] d,
                               input logic [31:0] t);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_data"},  32'(out_data),  d);
        check({tag, "_ts"},    32'(out_ts),    t);
    endtask

    task automatic do_clear;
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    logic [7:0] t2_acc [5] = '{8'h03, 8'h03, 8'h07, 8'h07, 8'h01};
    logic       t2_v   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] t2_d   [5] = '{8'h03, 8'h00, 8'h07, 8'h00, 8'h01};
    int unsigned t2_t  [5] = '{0, 0, 2, 0, 4};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; en = 1'b0; clear = 1'b0; out_ready = 1'b0; acc_in = '0;
        #2;
        expect_head("rst", 1'b0, 32'd0, 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_level", 32'(level),    32'd0);
        step(); step();
        reset_n = 1'b1;
        step();

        // Constant accumulator: only the ARM sample is recorded.
        en = 1'b1; acc_in = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t1_level", 32'(level), 32'd1);
        end
        expect_head("t1", 1'b1, 32'h00, ets(0));
        check("t1_ovf", 32'(overflow), 32'd0);
        en = 1'b0;
        do_clear();
        check("t1_clr_level", 32'(level), 32'd0);

        // Change detection with a consumer always ready.
        out_ready = 1'b1; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            acc_in = t2_acc[i];
            step();
            expect_head("t2", t2_v[i], 32'(t2_d[i]), ets(t2_t[i]));
        end
        en = 1'b0;
        step();
        check("t2_empty", 32'(out_valid), 32'd0);
        do_clear();

        // Overflow: DEPTH+2 distinct values with no consumer.
        out_ready = 1'b0; en = 1'b1;
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            acc_in = 8'(8'h10 + i);
            step();
            if (i == int'(DEPTH) - 1) begin
                check("t3_full_level", 32'(level), DEPTH);
                check("t3_full_ovf",   32'(overflow), 32'd0);
            end
        end
        check("t3_level", 32'(level),    DEPTH);
        check("t3_ovf",   32'(overflow), 32'd1);
        en = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < int'(DEPTH); k++) begin
            expect_head("t3_drain", 1'b1, 32'(8'(8'h10 + k)), ets(k));
            step();
        end
        check("t3_drained", 32'(out_valid), 32'd0);
        check("t3_sticky",  32'(overflow),  32'd1);
        do_clear();
        check("t3_clr_ovf", 32'(overflow), 32'd0);

        // Full buffer with simultaneous push and pop.
        out_ready = 1'b0; en = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            acc_in = 8'(8'h40 + i);
            step();
        end
        check("t4_full_level", 32'(level), DEPTH);
        out_ready = 1'b1; acc_in = 8'h99;
        step();
        check("t4_pp_level", 32'(level),    DEPTH);
        check("t4_pp_ovf",   32'(overflow), 32'd0);
        en = 1'b0;
        for (int k = 0; k < int'(DEPTH) - 1; k++) begin
            expect_head("t4_drain", 1'b1, 32'(8'(8'h41 + k)), ets(k + 1));
            step();
        end
        expect_head("t4_last", 1'b1, 32'h99, ets(DEPTH));
        step();
        check("t4_drained", 32'(out_valid), 32'd0);
        do_clear();

        // Re-enable re-arms; disabled cycles do not advance the stamp.
        out_ready = 1'b0; en = 1'b1; acc_in = 8'h05;
        step();
        check("t5_arm1_level", 32'(level), 32'd1);
        step();
        check("t5_run_level", 32'(level), 32'd1);
        en = 1'b0;
        step(); step(); step();
        check("t5_idle_level", 32'(level), 32'd1);
        en = 1'b1;
        step();
        check("t5_arm2_level", 32'(level), 32'd2);
        en = 1'b0; out_ready = 1'b1;
        expect_head("t5_e0", 1'b1, 32'h05, ets(0));
        step();
        expect_head("t5_e1", 1'b1, 32'h05, ets(2));
        step();
        check("t5_drained", 32'(out_valid), 32'd0);
        do_clear();

        // Asynchronous reset mid-drain, then clear with the same effect.
        out_ready = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            acc_in = 8'(8'h21 + i);
            step();
        end
        check("t6_fill_level", 32'(level), 32'd4);
        en = 1'b0; out_ready = 1'b1;
        step();
        check("t6_pend_level", 32'(level), 32'd3);
        expect_head("t6_head", 1'b1, 32'h22, ets(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_level", 32'(level),     32'd0);
        check("t6_rst_data",  32'(out_data),  32'd0);
        out_ready = 1'b0;
        step();
        reset_n = 1'b1; acc_in = 8'h00; en = 1'b1;
        step();
        expect_head("t6_arm", 1'b1, 32'h00, ets(0));
        check("t6_arm_level", 32'(level), 32'd1);
        acc_in = 8'h31; step();
        acc_in = 8'h32; step();
        check("t6_refill_level", 32'(level), 32'd3);
        acc_in = 8'h33; out_ready = 1'b1;
        do_clear();
        check("t6_clr_level", 32'(level),     32'd0);
        check("t6_clr_valid", 32'(out_valid), 32'd0);
        check("t6_clr_ovf",   32'(overflow),  32'd0);
        out_ready = 1'b0;
        step();
        expect_head("t6_rearm", 1'b1, 32'h33, ets(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lipsi_acc_tracer.md
# lipsi_acc_tracer

Parametrised accumulator trace unit for the Lipsi processor. It samples the processor accumulator bus every cycle and records each value change, plus an optional cycle timestamp, into an on-chip circular buffer. A valid/ready port drains the buffer. It sits beside `lipsi_processor` and replaces bench-only waveform inspection of `acc` with a synthesizable, self-contained trace source.

## Interface
Parameters:
- `DATA_W`, 8: accumulator width traced.
- `DEPTH`, 16: trace entries; power of two, ≥2.
- `TS_W`, 16: timestamp width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `en` in 1: capture enable.
- `clear` in 1: synchronous flush of buffer, overflow flag and timestamp.
- `acc_in` in DATA_W: processor accumulator.
- `out_valid` out 1: head entry available.
- `out_ready` in 1: consumer accepts head.
- `out_data` out DATA_W: recorded accumulator value.
- `out_ts` out TS_W: cycle stamp of the recorded value.
- `overflow` out 1: sticky; at least one change was dropped.
- `level` out $clog2(DEPTH)+1: current entry count.

## Operation
- FSM states:
  - IDLE: `en`=0; no capture.
  - ARM: first enabled cycle; captures `acc_in` unconditionally and loads `prev_acc`.
  - RUN: captures only when `acc_in != prev_acc`.
- FSM transitions:
  - IDLE→ARM when `en`=1.
  - ARM→RUN next cycle.
  - ARM/RUN→IDLE when `en`=0.
  - Re-enabling always passes through ARM.
- Timestamp counter:
  - Increments by 1 every cycle while `en`=1.
  - Wraps modulo 2^TS_W.
  - Holds while `en`=0.
  - Entry stamp is the counter value at the sampling edge.
- Buffer is a circular FIFO with read/write pointers one bit wider than the address.
  - Full when the pointer MSBs differ and the lower bits are equal.
  - Empty when the pointers are equal.
- Push when full:
  - Entry dropped; `overflow` set.
  - If the same cycle also pops, the push is accepted and nothing is dropped.
- Pop occurs when `out_valid && out_ready`.
- `out_data` and `out_ts` are first-word-fall-through from the head entry; they hold while stalled.
- `out_data` and `out_ts` are 0 when empty.
- `clear`:
  - Empties the buffer, clears `overflow` and zeroes the counter.
  - FSM goes to ARM if `en`=1, else IDLE.
  - `clear` has priority over push and pop in the same cycle.

## Timing
- Reset values:
  - FSM IDLE.
  - `out_valid`=0, `out_data`=0, `out_ts`=0, `overflow`=0, `level`=0.
  - Pointers 0; counter 0; `prev_acc`=0.
- Latency:
  - Change sampled at edge N appears on `out_valid` after edge N when the buffer is empty, i.e. one cycle.
  - `level` updates on the same edge.
- Pop at edge N exposes the next entry after edge N; back-to-back pops sustain 1 entry per cycle.
- Reset asserted mid-trace:
  - Discards all entries immediately (asynchronous).
  - The first capture after release is the ARM sample.
- `level` reaches DEPTH exactly when full.

## Configuration
- `LIPSI_TRACE_TS_EN` defined:
  - Timestamp counter instantiated.
  - Buffer entries are DATA_W+TS_W wide.
  - `out_ts` is driven as described above.
- `LIPSI_TRACE_TS_EN` undefined:
  - No counter.
  - Buffer entries are DATA_W wide.
  - `out_ts` tied to 0.
  - Port list unchanged.

## Structure
- Shared package `lipsi_pkg`:
  - FSM state enum: IDLE, ARM, RUN.
  - Default constants for `DATA_W`, `DEPTH`, `TS_W`.
- One sub-module, `lipsi_trace_fifo`:
  - Parametrised width and depth.
  - Push/pop/clear inputs; full/empty/level outputs.
  - FWFT head output.
- The top level holds the FSM, change detector, counter and overflow logic.

## Test plan
- Reset, then `en`=1 with `acc_in`=0x00 held for 5 cycles → exactly one entry {0x00, ts=0}; `level`=1; `overflow`=0.
- `acc_in` sequence 0x03, 0x03, 0x07, 0x07, 0x01 on ts 0..4 with `out_ready`=1 → entries 0x03@0, 0x07@2, 0x01@4 in order.
- `out_ready`=0, DEPTH+2 distinct values → `level`=DEPTH and `overflow`=1; drain yields the first DEPTH values only.
- Full buffer with push and pop in the same cycle → `level` stays DEPTH; `overflow` stays 0; the new value is last out.
- Toggle `en` 1→0→1 with unchanged `acc_in`=0x05 → second ARM records 0x05 again; ts excludes the disabled cycles.
- Assert `reset_n`=0 mid-drain with 3 entries pending → `out_valid`=0 and `level`=0 immediately; `clear` pulse gives the same result on the next edge.
